// File: rtl/vector_execute_unit.sv
// Multicycle vector ALU for the execute stage.
// Treats a VEC_W-bit vector as unsigned LANE_W-bit lanes and computes
// LANES_PER_CYCLE lanes per clock. The operation's inputs are captured on
// accept, so the pipeline may change its inputs freely while the unit runs.
//
// Handshake: start_execute is a request that is only looked at in IDLE or
// DONE. It is accepted on the first rising edge that sees it high in one of
// those states, and there is no back-pressure on the result. done is a
// one-cycle pulse that marks alu_vector_result_execute, vector_zero and
// illegal_op as valid. stall_pipeline holds the upstream registers from the
// accept cycle until the last RUN cycle.
//
// The FSM state can be observed from the ports: busy=1 means RUN, done=1
// means DONE, and IDLE is the case where both are low.
module vector_execute_unit #(
  parameter int VEC_W           = 128,
  parameter int LANE_W          = 8,
  parameter int LANES_PER_CYCLE = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_execute,
  input  logic [4:0]        aluVectorOp_execute,
  input  logic [VEC_W-1:0]  vector_srcA_execute,
  input  logic [VEC_W-1:0]  vector_srcB_execute,
  input  logic [LANE_W-1:0] scalar_src_execute,
  output logic              busy,
  output logic              done,
  output logic              stall_pipeline,
  output logic [VEC_W-1:0]  alu_vector_result_execute,
  output logic              vector_zero,
  output logic              illegal_op
);

  localparam int NUM_LANES = VEC_W / LANE_W;
  localparam int NUM_GROUPS = NUM_LANES / LANES_PER_CYCLE;
  localparam int GW = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;
  localparam int SHW = (LANE_W > 1) ? $clog2(LANE_W) : 1;
  localparam logic [GW-1:0] LAST_GROUP = GW'(NUM_GROUPS - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [4:0] OP_VADD  = 5'd0;
  localparam logic [4:0] OP_VSUB  = 5'd1;
  localparam logic [4:0] OP_VAND  = 5'd2;
  localparam logic [4:0] OP_VOR   = 5'd3;
  localparam logic [4:0] OP_VXOR  = 5'd4;
  localparam logic [4:0] OP_VSLL  = 5'd5;
  localparam logic [4:0] OP_VSRL  = 5'd6;
  localparam logic [4:0] OP_VMUL  = 5'd7;
  localparam logic [4:0] OP_VADDS = 5'd8;
  localparam logic [4:0] OP_VMULS = 5'd9;

  logic [1:0]        state_q;
  logic [GW-1:0]     group_q;
  logic [4:0]        op_q;
  logic [VEC_W-1:0]  src_a_q;
  logic [VEC_W-1:0]  src_b_q;
  logic [LANE_W-1:0] scalar_q;
  logic              illegal_q;
  logic [VEC_W-1:0]  acc_q;
  logic [VEC_W-1:0]  acc_next;
  logic              accept;

  // One lane of the selected operation. Arithmetic wraps within the lane.
  // Undefined opcodes produce 0.
  function automatic logic [LANE_W-1:0] lane_op(
    input logic [4:0]        op,
    input logic [LANE_W-1:0] a,
    input logic [LANE_W-1:0] b,
    input logic [LANE_W-1:0] s
  );
    logic [2*LANE_W-1:0] prod;
    logic [LANE_W-1:0]   r;
    prod = '0;
    r    = '0;
    case (op)
      OP_VADD:  r = a + b;
      OP_VSUB:  r = a - b;
      OP_VAND:  r = a & b;
      OP_VOR:   r = a | b;
      OP_VXOR:  r = a ^ b;
      OP_VSLL:  r = a << s[SHW-1:0];
      OP_VSRL:  r = a >> s[SHW-1:0];
      OP_VMUL: begin
        prod = a * b;
        r    = prod[LANE_W-1:0];
      end
      OP_VADDS: r = a + s;
      OP_VMULS: begin
        prod = a * s;
        r    = prod[LANE_W-1:0];
      end
      default:  r = '0;
    endcase
    return r;
  endfunction

  assign accept = start_execute && ((state_q == S_IDLE) || (state_q == S_DONE));

  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_DONE);

  // The stall covers the accept cycle as well, including a back-to-back
  // accept in DONE. This keeps the stall continuous across consecutive
  // operations.
  assign stall_pipeline = busy || accept;

  // Accumulator with the current lane group filled in from the latched operands
  always_comb begin
    acc_next = acc_q;
    for (int j = 0; j < LANES_PER_CYCLE; j++) begin
      acc_next[(int'(group_q) * LANES_PER_CYCLE + j) * LANE_W +: LANE_W] =
        lane_op(op_q,
                src_a_q[(int'(group_q) * LANES_PER_CYCLE + j) * LANE_W +: LANE_W],
                src_b_q[(int'(group_q) * LANES_PER_CYCLE + j) * LANE_W +: LANE_W],
                scalar_q);
    end
  end

  // FSM, operand capture, group iteration and the result register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q                   <= S_IDLE;
      group_q                   <= '0;
      op_q                      <= '0;
      src_a_q                   <= '0;
      src_b_q                   <= '0;
      scalar_q                  <= '0;
      illegal_q                 <= 1'b0;
      acc_q                     <= '0;
      alu_vector_result_execute <= '0;
      vector_zero               <= 1'b0;
      illegal_op                <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start_execute) begin
            state_q   <= S_RUN;
            group_q   <= '0;
            acc_q     <= '0;
            op_q      <= aluVectorOp_execute;
            src_a_q   <= vector_srcA_execute;
            src_b_q   <= vector_srcB_execute;
            scalar_q  <= scalar_src_execute;
            illegal_q <= (aluVectorOp_execute > OP_VMULS);
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_RUN: begin
          acc_q <= acc_next;
          if (group_q == LAST_GROUP) begin
            state_q                   <= S_DONE;
            group_q                   <= '0;
            alu_vector_result_execute <= acc_next;
            vector_zero               <= (acc_next == '0);
            illegal_op                <= illegal_q;
          end else begin
            group_q <= group_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vector_execute_unit.sv
// Directed bench for vector_execute_unit. It applies a table of hand-computed
// vectors and then runs sequences for reset during RUN and for back-to-back
// operations that include an illegal opcode.
module tb_vector_execute_unit;

  logic         clk = 1'b0;
  logic         reset;
  logic         start_execute;
  logic [4:0]   op;
  logic [127:0] src_a;
  logic [127:0] src_b;
  logic [7:0]   scalar;
  logic         busy;
  logic         done;
  logic         stall_pipeline;
  logic [127:0] result;
  logic         vector_zero;
  logic         illegal_op;

  int checks = 0;
  int errors = 0;
  logic [127:0] exp_prev;

  typedef struct {
    logic [4:0]   op;
    logic [127:0] a;
    logic [127:0] b;
    logic [7:0]   s;
    logic [127:0] res;
    logic         zero;
    logic         ill;
    string        name;
  } vec_t;

  vec_t tbl[12];

  vector_execute_unit dut (
    .clk                       (clk),
    .reset                     (reset),
    .start_execute             (start_execute),
    .aluVectorOp_execute       (op),
    .vector_srcA_execute       (src_a),
    .vector_srcB_execute       (src_b),
    .scalar_src_execute        (scalar),
    .busy                      (busy),
    .done                      (done),
    .stall_pipeline            (stall_pipeline),
    .alu_vector_result_execute (result),
    .vector_zero               (vector_zero),
    .illegal_op                (illegal_op)
  );

  // clock
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Run one operation and check latency, result hold during RUN, and the outputs.
  task automatic run_vec(input vec_t v);
    @(negedge clk);
    start_execute = 1'b1;
    op = v.op; src_a = v.a; src_b = v.b; scalar = v.s;
    #1 chk({v.name, " stall_accept"}, stall_pipeline, 1'b1);
    @(posedge clk);
    #1;
    start_execute = 1'b0;
    op = 5'd7; src_a = ~v.a; src_b = {$urandom, $urandom, $urandom, $urandom}; scalar = ~v.s;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      #1;
      if (k < 4) begin
        chk({v.name, " busy_run"}, busy, 1'b1);
        chk({v.name, " done_early"}, done, 1'b0);
        chk({v.name, " stall_run"}, stall_pipeline, 1'b1);
        chk({v.name, " result_hold"}, result, exp_prev);
      end else begin
        chk({v.name, " done"}, done, 1'b1);
        chk({v.name, " busy_done"}, busy, 1'b0);
        chk({v.name, " result"}, result, v.res);
        chk({v.name, " zero"}, vector_zero, v.zero);
        chk({v.name, " illegal"}, illegal_op, v.ill);
        chk({v.name, " stall_done"}, stall_pipeline, 1'b0);
      end
    end
    @(posedge clk);
    #1;
    chk({v.name, " done_pulse"}, done, 1'b0);
    chk({v.name, " idle"}, busy, 1'b0);
    exp_prev = v.res;
  endtask

  initial begin
    tbl[0]  = '{5'd0, {16{8'hF0}}, {16{8'h20}}, 8'h00, {16{8'h10}}, 1'b0, 1'b0, "vadd_wrap"};
    tbl[1]  = '{5'd1, 128'h0123456789ABCDEF0123456789ABCDEF, 128'h0123456789ABCDEF0123456789ABCDEF,
                8'h00, 128'h0, 1'b1, 1'b0, "vsub_zero"};
    tbl[2]  = '{5'd5, {16{8'h81}}, 128'h0, 8'h0B, {16{8'h08}}, 1'b0, 1'b0, "vsll"};
    tbl[3]  = '{5'd9, 128'h0F0E0D0C0B0A09080706050403020100, 128'h0, 8'h11,
                128'hFFEEDDCCBBAA99887766554433221100, 1'b0, 1'b0, "vmuls"};
    tbl[4]  = '{5'd2, {16{8'hF0}}, {16{8'h3C}}, 8'h00, {16{8'h30}}, 1'b0, 1'b0, "vand"};
    tbl[5]  = '{5'd31, {16{8'h55}}, {16{8'h66}}, 8'h77, 128'h0, 1'b1, 1'b1, "illegal31"};
    tbl[6]  = '{5'd3, {16{8'hF0}}, {16{8'h3C}}, 8'h00, {16{8'hFC}}, 1'b0, 1'b0, "vor"};
    tbl[7]  = '{5'd4, {16{8'hF0}}, {16{8'h3C}}, 8'h00, {16{8'hCC}}, 1'b0, 1'b0, "vxor"};
    tbl[8]  = '{5'd6, {16{8'h81}}, 128'h0, 8'hFF, {16{8'h01}}, 1'b0, 1'b0, "vsrl"};
    tbl[9]  = '{5'd7, 128'h0F0E0D0C0B0A09080706050403020100, 128'h0F0E0D0C0B0A09080706050403020100,
                8'h00, 128'hE1C4A990796451403124191009040100, 1'b0, 1'b0, "vmul"};
    tbl[10] = '{5'd8, 128'h0F0E0D0C0B0A09080706050403020100, 128'h0, 8'hF8,
                128'h0706050403020100FFFEFDFCFBFAF9F8, 1'b0, 1'b0, "vadds"};
    tbl[11] = '{5'd1, 128'h0, {16{8'h01}}, 8'h00, {16{8'hFF}}, 1'b0, 1'b0, "vsub_wrap"};

    // reset
    reset = 1'b1; start_execute = 1'b0; op = '0; src_a = '0; src_b = '0; scalar = '0;
    exp_prev = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst busy", busy, 1'b0);
    chk("rst done", done, 1'b0);
    chk("rst result", result, 128'h0);
    chk("rst zero", vector_zero, 1'b0);
    chk("rst illegal", illegal_op, 1'b0);
    chk("rst stall", stall_pipeline, 1'b0);

    // An op leaves a nonzero result, which the reset during RUN must clear.
    run_vec(tbl[0]);
    @(negedge clk);
    start_execute = 1'b1; op = 5'd0; src_a = {16{8'h01}}; src_b = {16{8'h02}};
    @(posedge clk);
    #1 start_execute = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    chk("midrst busy", busy, 1'b0);
    chk("midrst done", done, 1'b0);
    chk("midrst result", result, 128'h0);
    chk("midrst zero", vector_zero, 1'b0);
    chk("midrst stall", stall_pipeline, 1'b0);
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1 chk("midrst no_done", {busy, done}, 2'b00);
    end
    exp_prev = '0;

    // table
    for (int i = 0; i < 12; i++) run_vec(tbl[i]);

    // Back-to-back VADD then illegal op 20, with start held and pulsed during RUN.
    @(negedge clk);
    start_execute = 1'b1; op = 5'd0; src_a = {16{8'hF0}}; src_b = {16{8'h20}}; scalar = 8'h00;
    #1 chk("b2b stall_accept", stall_pipeline, 1'b1);
    @(posedge clk);
    #1 op = 5'd20; src_a = ~src_a; src_b = ~src_b;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk);
      #1;
      chk("b2b run1 busy", busy, 1'b1);
      chk("b2b run1 stall", stall_pipeline, 1'b1);
      chk("b2b run1 done", done, 1'b0);
    end
    @(posedge clk);
    #1;
    chk("b2b done1", done, 1'b1);
    chk("b2b result1", result, {16{8'h10}});
    chk("b2b illegal1", illegal_op, 1'b0);
    chk("b2b stall_done1", stall_pipeline, 1'b1);
    @(posedge clk);
    #1;
    chk("b2b no_bubble", busy, 1'b1);
    chk("b2b done_pulse", done, 1'b0);
    chk("b2b result_hold", result, {16{8'h10}});
    start_execute = 1'b0;
    for (int j = 1; j <= 3; j++) begin
      @(posedge clk);
      #1;
      chk("b2b run2 busy", busy, 1'b1);
      chk("b2b run2 stall", stall_pipeline, 1'b1);
      chk("b2b run2 done", done, 1'b0);
      start_execute = (j == 1);
    end
    @(posedge clk);
    #1;
    chk("b2b done2", done, 1'b1);
    chk("b2b result2", result, 128'h0);
    chk("b2b illegal2", illegal_op, 1'b1);
    chk("b2b zero2", vector_zero, 1'b1);
    chk("b2b stall_done2", stall_pipeline, 1'b0);
    @(posedge clk);
    #1;
    chk("b2b idle", {busy, done}, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
